// File: rtl/addr_stream_reader.sv
// Streams SRAM reads at addresses supplied by an upstream address generator
// into a small output FIFO, issuing reads only while buffer credit remains.
module addr_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           total_count,
  output logic                  step,
  input  logic [15:0]           addr_in,
  output logic                  mem_ren,
  output logic [15:0]           mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [15:0]           issued, total;
  logic                  inflight;
  logic                  zero_done;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                  push, pop, credit_ok, accept;

  // Credit counts the word still in flight but deliberately ignores a same-cycle pop.
  assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_C;
  assign accept    = (state == IDLE) && start && (total_count != 16'd0);

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    done      = zero_done;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        step = (issued < total) && credit_ok;
        if (step && (issued + 16'd1 == total)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!inflight && (fifo_count == '0)) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_ren   = step;
  assign mem_raddr = addr_in;
  assign busy      = (state != IDLE);
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign push      = inflight;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      issued     <= '0;
      total      <= '0;
      inflight   <= 1'b0;
      zero_done  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state     <= state_nxt;
      inflight  <= mem_ren;
      zero_done <= (state == IDLE) && start && (total_count == 16'd0);
      if (accept) begin
        issued <= '0;
        total  <= total_count;
      end else if (step) begin
        issued <= issued + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Read-data stage: buffer storage carries no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_addr_stream_reader.sv
// Scoreboard bench for addr_stream_reader with a nested address generator
// and a one-cycle-latency SRAM model around the DUT.
module tb_addr_stream_reader;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [15:0]   total_count, addr_in;
  logic [DW-1:0] mem_rdata;
  logic          step, mem_ren, out_valid, busy, done;
  logic [15:0]   mem_raddr;
  logic [DW-1:0] out_data;

  addr_stream_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total_count(total_count),
    .step(step), .addr_in(addr_in), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h5A3C;
  endfunction

  // Upstream nested address generator: x inner, y outer, advances on step.
  int gxm = 1, gym = 1, gxs = 0, gys = 0, goff = 0;
  int gx = 0, gy = 0;
  logic gen_clr = 1'b1;
  always_comb addr_in = 16'(goff + gy * gys + gx * gxs);
  always @(posedge clk) begin
    if (gen_clr) begin
      gx <= 0;
      gy <= 0;
    end else if (step) begin
      if (gx + 1 >= gxm) begin
        gx <= 0;
        gy <= (gy + 1 >= gym) ? 0 : gy + 1;
      end else begin
        gx <= gx + 1;
      end
    end
  end

  // SRAM model: data one cycle after the read enable, garbage otherwise.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_fn(mem_raddr);
    else         mem_rdata <= DW'($urandom);
  end

  logic [15:0]   exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int reads_cnt = 0, pops_cnt = 0, done_cnt = 0;

  // Monitor: compares every read address and every delivered word.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ren_is_step", 32'(mem_ren), 32'(step));
      if (busy) begin
        n_checks++;
        if (reads_cnt - pops_cnt > DEPTH) begin
          n_fail++;
          $display("FAIL occupancy: got %0d allowed %0d", reads_cnt - pops_cnt, DEPTH);
        end
      end
      if (mem_ren) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_read: got read at 0x%0h expected none", mem_raddr);
        end else begin
          check("raddr", 32'(mem_raddr), 32'(exp_addr_q.pop_front()));
        end
        reads_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_word: got 0x%0h expected none", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
        end
        pops_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_pass(input int tc, input int xm, input int ym, input int xs,
                           input int ys, input int off);
    logic [15:0] a;
    gxm = xm; gym = ym; gxs = xs; gys = ys; goff = off;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < tc; i++) begin
      a = 16'(off + ((i / xm) % ym) * ys + (i % xm) * xs);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_fn(a));
    end
    reads_cnt = 0; pops_cnt = 0; done_cnt = 0;
  endtask

  // mode: 0 always ready, 1 toggling 1/0, 2 random
  task automatic run_pass(input int tc, input int xm, input int ym, input int xs,
                          input int ys, input int off, input int mode, input int hold,
                          input int extra_start, output int lat);
    int cyc;
    bit got;
    @(posedge clk); #1;
    gen_clr = 1'b1; out_ready = 1'b0;
    load_pass(tc, xm, ym, xs, ys, off);
    @(posedge clk); #1;
    gen_clr = 1'b0; start = 1'b1; total_count = 16'(tc);
    @(posedge clk); #1;
    start = 1'b0; total_count = 16'($urandom);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 3000) begin
      if (cyc < hold) out_ready = 1'b0;
      else if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (cyc % 2 == 0);
      else out_ready = 1'($urandom_range(0, 1));
      if (extra_start != 0 && cyc == extra_start) begin
        start = 1'b1; total_count = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) got = 1'b1;
      if (hold > 0 && cyc == hold - 1) begin
        check("stall_reads", 32'(reads_cnt), 32'((tc < DEPTH) ? tc : DEPTH));
        check("stall_step", 32'(step), 32'(0));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL pass_timeout: got no done after %0d cycles expected done", cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'(1));
    check("reads_total", 32'(reads_cnt), 32'(tc));
    check("words_total", 32'(pops_cnt), 32'(tc));
    check("busy_after", 32'(busy), 32'(0));
    lat = cyc;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_step"},  32'(step),      32'(0));
    check({tag, "_ren"},   32'(mem_ren),   32'(0));
    check({tag, "_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_busy"},  32'(busy),      32'(0));
    check({tag, "_done"},  32'(done),      32'(0));
  endtask

  int lat_a, lat_b, lat_tmp, wait_cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; total_count = 16'd0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Linear 3x2 pattern starting at 0x100.
    run_pass(6, 3, 2, 1, 3, 16'h100, 0, 0, 0, lat_a);

    // Back-pressure: only FIFO_DEPTH reads may issue while stalled.
    run_pass(8, 4, 2, 2, 16, 16'h2000, 0, 12, 0, lat_tmp);

    // Alternating ready, 16 words.
    run_pass(16, 4, 4, 1, 8, 16'h0400, 1, 0, 0, lat_tmp);

    // Zero-length pass.
    @(posedge clk); #1;
    reads_cnt = 0; done_cnt = 0;
    start = 1'b1; total_count = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(done), 32'(1));
    check("zero_busy", 32'(busy), 32'(0));
    @(negedge clk);
    check("zero_done_once", 32'(done), 32'(0));
    check("zero_reads", 32'(reads_cnt), 32'(0));
    check("zero_done_cnt", 32'(done_cnt), 32'(1));

    // Reset in the middle of a pass.
    @(posedge clk); #1;
    gen_clr = 1'b1; out_ready = 1'b1;
    load_pass(6, 3, 2, 1, 3, 16'h300);
    @(posedge clk); #1;
    gen_clr = 1'b0; start = 1'b1; total_count = 16'd6;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc = 0;
    while (reads_cnt < 3 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("mid_reads_seen", 32'(reads_cnt), 32'(3));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    check_idle_outputs("mid_reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_release");
    run_pass(2, 2, 1, 5, 0, 16'h0777, 0, 0, 0, lat_tmp);

    // Start pulse during RUN must not change anything.
    run_pass(6, 3, 2, 1, 3, 16'h100, 0, 0, 2, lat_b);
    check("restart_latency", 32'(lat_b), 32'(lat_a));

    // Randomized passes.
    for (int p = 0; p < 8; p++) begin
      run_pass($urandom_range(1, 20), $urandom_range(1, 5), $urandom_range(1, 4),
               $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 65535),
               $urandom_range(0, 2), 0, 0, lat_tmp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/addr_stream_reader.md
ADDR_STREAM_READER -- requirements
Module: addr_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of memory read data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a pass; sampled only in IDLE.
REQ-006 SHALL have port total_count  input  16  number of addresses in the pass; sampled with start.
REQ-007 SHALL have port step  output  1  advance request to the upstream nested address generator.
REQ-008 SHALL have port addr_in  input  16  current address from the generator's addr_out; valid in the cycle step is high.
REQ-009 SHALL have port mem_ren  output  1  SRAM read enable.
REQ-010 SHALL have port mem_raddr  output  16  SRAM read address.
REQ-011 SHALL have port mem_rdata  input  DATA_WIDTH  SRAM read data, valid exactly 1 cycle after mem_ren.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-014 SHALL have port out_data  output  DATA_WIDTH  head word of the output buffer.
REQ-015 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at pass completion.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-018 IDLE: start=1 and total_count!=0 -> RUN; latch total_count; clear issue counter.
REQ-019 IDLE: start=1 and total_count==0 -> stay IDLE; done=1 in the next cycle.
REQ-020 start in RUN or DRAIN SHALL be ignored, with no state change.
REQ-021 RUN: step=1 iff issued<total and (fifo_count + inflight) < FIFO_DEPTH; step is combinational from registered state only.
REQ-022 mem_ren SHALL equal step; mem_raddr SHALL equal addr_in (combinational pass-through, zero latency).
REQ-023 Each step SHALL increment the 16-bit issued counter by 1; counter does not wrap within a pass.
REQ-024 RUN -> DRAIN on the cycle the final read issues (issued becomes total).
REQ-025 inflight SHALL be a 1-bit register set by mem_ren and cleared the next cycle.
REQ-026 When inflight=1, mem_rdata SHALL be pushed into the FIFO that cycle.
REQ-027 out_valid SHALL equal FIFO non-empty; out_data SHALL equal the FIFO head; pop on out_valid & out_ready.
REQ-028 Simultaneous push and pop SHALL be supported in one cycle, including when the FIFO is full or empty-with-push; occupancy stays unchanged.
REQ-029 Credit check (REQ-021) SHALL ignore a same-cycle pop, so the FIFO never overflows.
REQ-030 Data order out SHALL equal the address issue order.
REQ-031 DRAIN -> IDLE when inflight=0 and FIFO empty; done=1 for exactly that transition cycle.
REQ-032 Only step is driven to the generator. Aligning the generator counters to the pattern origin is the host's responsibility.
REQ-033 out_ready low SHALL stall issue only through FIFO credit; data SHALL never be dropped.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and clear issued, total, inflight and the FIFO pointers and count.
REQ-035 During reset and in the cycle after release: step, mem_ren, out_valid, busy and done = 0.
REQ-036 Reset mid-pass SHALL discard buffered and in-flight data; mem_rdata returning after reset is ignored.

Verification
REQ-037 Generator x_max=3, y_max=2, x_stride=1, y_stride_op=1, offset=0x100; total_count=6; out_ready=1 -> reads at 0x100,0x101,0x102,0x103,0x104,0x105; six words out in order; done pulses once.
REQ-038 total_count=8, FIFO_DEPTH=4, out_ready=0 -> exactly 4 reads issue, then step stays 0; raising out_ready resumes issue; all 8 words delivered, none lost.
REQ-039 out_ready toggles 1,0 every cycle with total_count=16 -> output matches the reference model of the memory contents and addresses; FIFO count never exceeds 4.
REQ-040 start with total_count=0 -> no mem_ren; busy stays 0; done=1 one cycle later.
REQ-041 rst_n asserted after the 3rd of 6 reads -> outputs 0 immediately; a new start with total_count=2 completes cleanly with 2 words.
REQ-042 start pulsed during RUN -> ignored; issued count and done timing are unchanged.
